tbeb: RTL

- Receive-side 10b/8b decoder that converts 10-bit line code words into bytes plus a control-character flag.
- Tracks running disparity and flags code and disparity violations.
- Runs a comma-based synchronization state machine.
- Sits between the deserializer (word-aligned, fixed boundary) and the link layer, as the counterpart of the team's 8b/10b transmit encoder.

---
 rtl/tbeb_pkg.sv | 107 ++++++++++
 rtl/tbeb_if.sv | 17 +
 rtl/tbeb_sync_fsm.sv | 95 +++++++++
 rtl/tbeb.sv | 112 +++++++++++
 4 files changed

// File: rtl/tbeb_pkg.sv
// rtl/tbeb_pkg.sv - shared types, K-code constants and subblock decode tables for the 10b/8b decoder
package tbeb_pkg;

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } sync_state_t;

    localparam logic [9:0] K28_5_RDN  = 10'h0FA;
    localparam logic [9:0] K28_5_RDP  = 10'h305;
    localparam logic [7:0] K28_5_BYTE = 8'hBC;

    typedef struct packed {
        logic       legal;
        logic [4:0] val;
    } dec6_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] val;
    } dec4_t;

    // Both running-disparity forms of every data 6b code; K.28 is handled by the caller.
    function automatic dec6_t dec6(input logic [5:0] c);
        dec6_t r;
        r.legal = 1'b1;
        r.val   = 5'd0;
        case (c)
            6'b100111, 6'b011000: r.val = 5'd0;
            6'b011101, 6'b100010: r.val = 5'd1;
            6'b101101, 6'b010010: r.val = 5'd2;
            6'b110001:            r.val = 5'd3;
            6'b110101, 6'b001010: r.val = 5'd4;
            6'b101001:            r.val = 5'd5;
            6'b011001:            r.val = 5'd6;
            6'b111000, 6'b000111: r.val = 5'd7;
            6'b111001, 6'b000110: r.val = 5'd8;
            6'b100101:            r.val = 5'd9;
            6'b010101:            r.val = 5'd10;
            6'b110100:            r.val = 5'd11;
            6'b001101:            r.val = 5'd12;
            6'b101100:            r.val = 5'd13;
            6'b011100:            r.val = 5'd14;
            6'b010111, 6'b101000: r.val = 5'd15;
            6'b011011, 6'b100100: r.val = 5'd16;
            6'b100011:            r.val = 5'd17;
            6'b010011:            r.val = 5'd18;
            6'b110010:            r.val = 5'd19;
            6'b001011:            r.val = 5'd20;
            6'b101010:            r.val = 5'd21;
            6'b011010:            r.val = 5'd22;
            6'b111010, 6'b000101: r.val = 5'd23;
            6'b110011, 6'b001100: r.val = 5'd24;
            6'b100110:            r.val = 5'd25;
            6'b010110:            r.val = 5'd26;
            6'b110110, 6'b001001: r.val = 5'd27;
            6'b001110:            r.val = 5'd28;
            6'b101110, 6'b010001: r.val = 5'd29;
            6'b011110, 6'b100001: r.val = 5'd30;
            6'b101011, 6'b010100: r.val = 5'd31;
            default:              r.legal = 1'b0;
        endcase
        return r;
    endfunction

    // Data 4b codes other than the alternate A7 form, which depends on the 6b code.
    function automatic dec4_t dec4_data(input logic [3:0] c);
        dec4_t r;
        r.legal = 1'b1;
        r.val   = 3'd0;
        case (c)
            4'b0100, 4'b1011: r.val = 3'd0;
            4'b1001:          r.val = 3'd1;
            4'b0101:          r.val = 3'd2;
            4'b0011, 4'b1100: r.val = 3'd3;
            4'b0010, 4'b1101: r.val = 3'd4;
            4'b1010:          r.val = 3'd5;
            4'b0110:          r.val = 3'd6;
            4'b0001, 4'b1110: r.val = 3'd7;
            default:          r.legal = 1'b0;
        endcase
        return r;
    endfunction

    // 4b codes following K.28; the rd+ form (after 110000) is the bitwise complement.
    function automatic dec4_t dec4_k28(input logic [3:0] c, input logic rdp);
        dec4_t      r;
        logic [3:0] n;
        n       = rdp ? ~c : c;
        r.legal = 1'b1;
        r.val   = 3'd0;
        case (n)
            4'b0100: r.val = 3'd0;
            4'b1001: r.val = 3'd1;
            4'b0101: r.val = 3'd2;
            4'b0011: r.val = 3'd3;
            4'b0010: r.val = 3'd4;
            4'b1010: r.val = 3'd5;
            4'b0110: r.val = 3'd6;
            4'b1000: r.val = 3'd7;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tbeb_if.sv
// rtl/tbeb_if.sv - code word in / decoded byte out bundle for the 10b/8b decoder
interface tbeb_if;
    logic       tb_valid;
    logic [9:0] tb;
    logic       eb_valid;
    logic [7:0] eb;
    logic       k;
    logic       rd;
    logic       code_err;
    logic       disp_err;
    logic       sync;

    modport master (output tb_valid, tb,
                    input  eb_valid, eb, k, rd, code_err, disp_err, sync);
    modport slave  (input  tb_valid, tb,
                    output eb_valid, eb, k, rd, code_err, disp_err, sync);
endinterface

// File: rtl/tbeb_sync_fsm.sv
// rtl/tbeb_sync_fsm.sv - comma-based link synchronization state machine with error leaky bucket
module tbeb_sync_fsm
    import tbeb_pkg::*;
#(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_ERRS  = 4,
    parameter int GOOD_RUN   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic good,
    input  logic comma,
    output logic sync
);
    localparam int CW = $clog2(ACQ_COMMAS + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam logic [CW-1:0] C_MAX = CW'(ACQ_COMMAS);
    localparam logic [EW-1:0] E_MAX = EW'(LOSS_ERRS);

    sync_state_t   state_q, state_d;
    logic [CW-1:0] comma_q, comma_d;
    logic [EW-1:0] err_q, err_d;
    logic [GW-1:0] good_q, good_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOS;
            comma_q <= '0;
            err_q   <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            comma_q <= comma_d;
            err_q   <= err_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        comma_d = comma_q;
        err_d   = err_q;
        good_d  = good_q;
        if (valid) begin
            case (state_q)
                ST_LOS: begin
                    if (good && comma) begin
                        comma_d = CW'(1);
                        err_d   = '0;
                        good_d  = '0;
                        state_d = (ACQ_COMMAS <= 1) ? ST_SYNC : ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (good && comma) begin
                        if (comma_q != C_MAX) comma_d = comma_q + 1'b1;
                        if (int'(comma_q) + 1 >= ACQ_COMMAS) begin
                            state_d = ST_SYNC;
                            err_d   = '0;
                            good_d  = '0;
                        end
                    end else begin
                        state_d = ST_LOS;
                        comma_d = '0;
                    end
                end
                ST_SYNC: begin
                    if (!good) begin
                        good_d = '0;
                        if (err_q != E_MAX) err_d = err_q + 1'b1;
                        if (int'(err_q) + 1 >= LOSS_ERRS) begin
                            state_d = ST_LOS;
                            comma_d = '0;
                            err_d   = '0;
                        end
                    end else if (err_q == '0) begin
                        good_d = '0;
                    end else if (int'(good_q) + 1 >= GOOD_RUN) begin
                        // a full run of good words forgives exactly one counted error
                        err_d  = err_q - 1'b1;
                        good_d = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end
    end

    assign sync = (state_q == ST_SYNC);

endmodule

// File: rtl/tbeb.sv
// rtl/tbeb.sv - receive-side 10b/8b decoder with running disparity tracking and link sync
module tbeb
    import tbeb_pkg::*;
#(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_ERRS  = 4,
    parameter int GOOD_RUN   = 4
) (
    input  logic   clk,
    input  logic   reset,
    tbeb_if.slave  bus
);
    logic [5:0] six;
    logic [3:0] four;
    logic [3:0] ones;
    dec6_t      d6;
    dec4_t      d4;
    dec4_t      dk;
    logic       is_k28;
    logic       kx7;
    logic       a7_ok;
    logic       legal;
    logic       is_k;
    logic [7:0] byte_d;
    logic       disp_bad;
    logic       rd_next;
    logic       good;
    logic       comma;
    logic       sync_w;

    assign six  = bus.tb[9:4];
    assign four = bus.tb[3:0];
    assign ones = 4'($countones(bus.tb));

    always_comb begin
        d6     = dec6(six);
        d4     = dec4_data(four);
        dk     = dec4_k28(four, six == 6'b110000);
        is_k28 = (six == 6'b001111) || (six == 6'b110000);
        kx7    = ((six == 6'b111010 || six == 6'b110110 || six == 6'b101110 || six == 6'b011110)
                  && four == 4'b1000)
              || ((six == 6'b000101 || six == 6'b001001 || six == 6'b010001 || six == 6'b100001)
                  && four == 4'b0111);
        a7_ok  = (four == 4'b1000 || four == 4'b0111)
              && (six == 6'b110100 || six == 6'b101100 || six == 6'b011100
               || six == 6'b100011 || six == 6'b010011 || six == 6'b001011);
        legal  = 1'b0;
        is_k   = 1'b0;
        byte_d = 8'h00;
        if (is_k28) begin
            legal  = dk.legal;
            is_k   = dk.legal;
            byte_d = {dk.val, 5'd28};
        end else if (kx7) begin
            legal  = 1'b1;
            is_k   = 1'b1;
            byte_d = {3'd7, d6.val};
        end else if (d6.legal && a7_ok) begin
            legal  = 1'b1;
            byte_d = {3'd7, d6.val};
        end else if (d6.legal && d4.legal) begin
            legal  = 1'b1;
            byte_d = {d4.val, d6.val};
        end
        // words whose weight is outside 4..6 can never be valid line code
        if (!legal || ones < 4'd4 || ones > 4'd6) begin
            legal  = 1'b0;
            is_k   = 1'b0;
            byte_d = 8'h00;
        end
        disp_bad = (ones == 4'd6 && bus.rd) || (ones == 4'd4 && !bus.rd);
        rd_next  = (ones == 4'd6) ? 1'b1 : (ones == 4'd4) ? 1'b0 : bus.rd;
        good     = legal && !disp_bad;
        comma    = is_k && (byte_d == K28_5_BYTE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.eb_valid <= 1'b0;
            bus.eb       <= 8'h00;
            bus.k        <= 1'b0;
            bus.rd       <= 1'b0;
            bus.code_err <= 1'b0;
            bus.disp_err <= 1'b0;
        end else begin
            bus.eb_valid <= bus.tb_valid;
            if (bus.tb_valid) begin
                bus.eb       <= byte_d;
                bus.k        <= is_k;
                bus.rd       <= rd_next;
                bus.code_err <= !legal;
                bus.disp_err <= disp_bad;
            end
        end
    end

    tbeb_sync_fsm #(
        .ACQ_COMMAS (ACQ_COMMAS),
        .LOSS_ERRS  (LOSS_ERRS),
        .GOOD_RUN   (GOOD_RUN)
    ) u_sync_fsm (
        .clk   (clk),
        .reset (reset),
        .valid (bus.tb_valid),
        .good  (good),
        .comma (comma),
        .sync  (sync_w)
    );

    assign bus.sync = sync_w;

endmodule
